// File: rtl/maze_mover.sv
// Player-movement engine: incremental tile tracking with wall lookups over a req/ack port.
// Position is held as tile + in-tile offset plus absolute pixel coordinates, all updated together.
module maze_mover #(
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned TILE_W      = 40,
  parameter int unsigned TILE_H      = 40,
  parameter int unsigned NUM_COLS    = 16,
  parameter int unsigned NUM_ROWS    = 12,
  parameter int unsigned WALL_MARGIN = 2,
  parameter int unsigned SPRITE      = 10,
  parameter int unsigned STEP        = 2,
  parameter int unsigned START_X     = 394,
  parameter int unsigned START_Y     = 41,
  parameter int unsigned Y_OFFSET    = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic [3:0]         i_btn_dir,
  input  logic               i_restart,
  input  logic               i_level_change,
  output logic               o_wall_req,
  output logic [4:0]         o_wall_row,
  output logic [4:0]         o_wall_col,
  input  logic               i_wall_ack,
  input  logic [3:0]         i_wall_data,
  output logic [COORD_W-1:0] o_pos_x,
  output logic [COORD_W-1:0] o_pos_y,
  output logic [4:0]         o_tile_row,
  output logic [4:0]         o_tile_col,
  output logic               o_busy,
  output logic               o_blocked
);

  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {StIdle, StReqCur, StReqAdj, StDecide} state_e;

  localparam coord_t     C_STEP    = coord_t'(STEP);
  localparam coord_t     C_MARGIN  = coord_t'(WALL_MARGIN);
  localparam coord_t     C_SPRITE  = coord_t'(SPRITE);
  localparam coord_t     C_TILE_W  = coord_t'(TILE_W);
  localparam coord_t     C_TILE_H  = coord_t'(TILE_H);
  localparam coord_t     C_Y_OFF   = coord_t'(Y_OFFSET);
  localparam coord_t     C_ARENA_W = coord_t'(NUM_COLS * TILE_W);
  localparam coord_t     C_ARENA_H = coord_t'(NUM_ROWS * TILE_H);
  localparam coord_t     C_X_IN0   = coord_t'(START_X % TILE_W);
  localparam coord_t     C_Y_IN0   = coord_t'(START_Y % TILE_H);
  localparam coord_t     C_POS_X0  = coord_t'(START_X);
  localparam coord_t     C_POS_Y0  = coord_t'(START_Y + Y_OFFSET);
  localparam logic [4:0] C_COL0    = 5'(START_X / TILE_W);
  localparam logic [4:0] C_ROW0    = 5'(START_Y / TILE_H);
  localparam logic [4:0] C_LAST_C  = 5'(NUM_COLS - 1);
  localparam logic [4:0] C_LAST_R  = 5'(NUM_ROWS - 1);

  state_e     r_state, w_state_d;
  logic [3:0] r_dir, w_dir_d;
  logic [4:0] r_col, w_col_d, r_row, w_row_d;
  logic [4:0] r_adj_col, w_adj_col_d, r_adj_row, w_adj_row_d;
  coord_t     r_x_in, w_x_in_d, r_y_in, w_y_in_d;
  coord_t     r_pos_x, w_pos_x_d, r_pos_y, w_pos_y_d;
  logic [3:0] r_cur_walls, w_cur_walls_d, r_adj_walls, w_adj_walls_d;
  logic       r_gap, w_gap_d;
  logic       r_blocked, w_blocked_d;
  logic       w_block;
  logic       w_one_hot;
  coord_t     w_maze_y;

  assign w_maze_y  = r_pos_y - C_Y_OFF;
  assign w_one_hot = (i_btn_dir == 4'b0001) || (i_btn_dir == 4'b0010) ||
                     (i_btn_dir == 4'b0100) || (i_btn_dir == 4'b1000);

  always_comb begin
    w_state_d     = r_state;
    w_dir_d       = r_dir;
    w_col_d       = r_col;
    w_row_d       = r_row;
    w_adj_col_d   = r_adj_col;
    w_adj_row_d   = r_adj_row;
    w_x_in_d      = r_x_in;
    w_y_in_d      = r_y_in;
    w_pos_x_d     = r_pos_x;
    w_pos_y_d     = r_pos_y;
    w_cur_walls_d = r_cur_walls;
    w_adj_walls_d = r_adj_walls;
    w_gap_d       = 1'b0;
    w_blocked_d   = 1'b0;
    w_block       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_tick && w_one_hot) begin
          w_dir_d     = i_btn_dir;
          w_adj_row_d = r_row;
          w_adj_col_d = r_col;
          case (i_btn_dir)
            4'b0001: if (r_row != 5'd0)     w_adj_row_d = r_row - 5'd1;
            4'b0010: if (r_col != 5'd0)     w_adj_col_d = r_col - 5'd1;
            4'b0100: if (r_col != C_LAST_C) w_adj_col_d = r_col + 5'd1;
            4'b1000: if (r_row != C_LAST_R) w_adj_row_d = r_row + 5'd1;
            default: ;
          endcase
          w_state_d = StReqCur;
        end
      end
      StReqCur: begin
        if (i_wall_ack) begin
          w_cur_walls_d = i_wall_data;
          if ((r_adj_row == r_row) && (r_adj_col == r_col)) begin
            w_adj_walls_d = 4'b0000;
            w_state_d     = StDecide;
          end else begin
            w_gap_d   = 1'b1;
            w_state_d = StReqAdj;
          end
        end
      end
      StReqAdj: begin
        // First cycle here is the mandatory request-low gap.
        if (!r_gap && i_wall_ack) begin
          w_adj_walls_d = i_wall_data;
          w_state_d     = StDecide;
        end
      end
      StDecide: begin
        unique case (r_dir)
          4'b0001: w_block = ((r_cur_walls[3] | r_adj_walls[2]) && (r_y_in <= C_MARGIN)) ||
                             (w_maze_y < C_STEP);
          4'b1000: w_block = ((r_cur_walls[2] | r_adj_walls[3]) &&
                              (r_y_in + C_SPRITE >= C_TILE_H - C_MARGIN)) ||
                             (w_maze_y + C_STEP + C_SPRITE > C_ARENA_H);
          4'b0010: w_block = ((r_cur_walls[1] | r_adj_walls[0]) && (r_x_in <= C_MARGIN)) ||
                             (r_pos_x < C_STEP);
          4'b0100: w_block = ((r_cur_walls[0] | r_adj_walls[1]) &&
                              (r_x_in + C_SPRITE >= C_TILE_W - C_MARGIN)) ||
                             (r_pos_x + C_STEP + C_SPRITE > C_ARENA_W);
          default: w_block = 1'b1;
        endcase
        if (w_block) begin
          w_blocked_d = 1'b1;
        end else begin
          unique case (r_dir)
            4'b0001: begin
              w_pos_y_d = r_pos_y - C_STEP;
              if (r_y_in < C_STEP) begin
                w_row_d  = r_row - 5'd1;
                w_y_in_d = r_y_in + C_TILE_H - C_STEP;
              end else w_y_in_d = r_y_in - C_STEP;
            end
            4'b1000: begin
              w_pos_y_d = r_pos_y + C_STEP;
              if (r_y_in + C_STEP >= C_TILE_H) begin
                w_row_d  = r_row + 5'd1;
                w_y_in_d = r_y_in - (C_TILE_H - C_STEP);
              end else w_y_in_d = r_y_in + C_STEP;
            end
            4'b0010: begin
              w_pos_x_d = r_pos_x - C_STEP;
              if (r_x_in < C_STEP) begin
                w_col_d  = r_col - 5'd1;
                w_x_in_d = r_x_in + C_TILE_W - C_STEP;
              end else w_x_in_d = r_x_in - C_STEP;
            end
            4'b0100: begin
              w_pos_x_d = r_pos_x + C_STEP;
              if (r_x_in + C_STEP >= C_TILE_W) begin
                w_col_d  = r_col + 5'd1;
                w_x_in_d = r_x_in - (C_TILE_W - C_STEP);
              end else w_x_in_d = r_x_in + C_STEP;
            end
            default: ;
          endcase
        end
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Reset, level change and restart all reload the spawn state and abort any lookup.
  always_ff @(posedge clk) begin
    if (!rst || i_level_change || i_restart) begin
      r_state     <= StIdle;
      r_dir       <= 4'b0000;
      r_col       <= C_COL0;
      r_row       <= C_ROW0;
      r_adj_col   <= C_COL0;
      r_adj_row   <= C_ROW0;
      r_x_in      <= C_X_IN0;
      r_y_in      <= C_Y_IN0;
      r_pos_x     <= C_POS_X0;
      r_pos_y     <= C_POS_Y0;
      r_cur_walls <= 4'b0000;
      r_adj_walls <= 4'b0000;
      r_gap       <= 1'b0;
      r_blocked   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_dir       <= w_dir_d;
      r_col       <= w_col_d;
      r_row       <= w_row_d;
      r_adj_col   <= w_adj_col_d;
      r_adj_row   <= w_adj_row_d;
      r_x_in      <= w_x_in_d;
      r_y_in      <= w_y_in_d;
      r_pos_x     <= w_pos_x_d;
      r_pos_y     <= w_pos_y_d;
      r_cur_walls <= w_cur_walls_d;
      r_adj_walls <= w_adj_walls_d;
      r_gap       <= w_gap_d;
      r_blocked   <= w_blocked_d;
    end
  end

  assign o_wall_req = (r_state == StReqCur) || ((r_state == StReqAdj) && !r_gap);
  assign o_wall_row = (r_state == StReqAdj) ? r_adj_row : r_row;
  assign o_wall_col = (r_state == StReqAdj) ? r_adj_col : r_col;
  assign o_pos_x    = r_pos_x;
  assign o_pos_y    = r_pos_y;
  assign o_tile_row = r_row;
  assign o_tile_col = r_col;
  assign o_busy     = (r_state != StIdle);
  assign o_blocked  = r_blocked;

endmodule

// File: tb/tb_maze_mover.sv
// Bench for maze_mover: maze-space pixel model with a wall ROM responder and per-cycle compare.
module tb_maze_mover;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_tick = 1'b0, i_restart = 1'b0, i_level_change = 1'b0;
  logic [3:0]  i_btn_dir = 4'b0000;
  logic        o_wall_req, i_wall_ack, o_busy, o_blocked;
  logic [4:0]  o_wall_row, o_wall_col, o_tile_row, o_tile_col;
  logic [3:0]  i_wall_data;
  logic [10:0] o_pos_x, o_pos_y;

  logic        resp_ack = 1'b0, man_ack = 1'b0, resp_en = 1'b1;
  logic [3:0]  resp_data = 4'b0000, man_data = 4'b0000;
  assign i_wall_ack  = resp_ack | man_ack;
  assign i_wall_data = man_ack ? man_data : resp_data;

  always #5 clk = ~clk;

  maze_mover dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn_dir(i_btn_dir), .i_restart(i_restart),
    .i_level_change(i_level_change), .o_wall_req(o_wall_req), .o_wall_row(o_wall_row),
    .o_wall_col(o_wall_col), .i_wall_ack(i_wall_ack), .i_wall_data(i_wall_data),
    .o_pos_x(o_pos_x), .o_pos_y(o_pos_y), .o_tile_row(o_tile_row), .o_tile_col(o_tile_col),
    .o_busy(o_busy), .o_blocked(o_blocked)
  );

  int total = 0, bad = 0;
  logic [3:0] walls [0:11][0:15];
  int mx = 394, my = 41;         // model position in maze space
  logic exp_blocked = 1'b0, chk_en = 1'b0;
  int mv_id = 0, exp_n = 0, ack_delay = 0;
  int exp_r [2], exp_c [2], seen_r [2], seen_c [2];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: whenever idle, outputs must match the model.
  initial begin
    bit pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!o_busy) begin
          check("pos_x", o_pos_x, mx);
          check("pos_y", o_pos_y, my + 100);
          check("tile_col", o_tile_col, mx / 40);
          check("tile_row", o_tile_row, my / 40);
          check("req_idle", o_wall_req, 0);
          if (pb) check("blocked_pulse", o_blocked, exp_blocked);
          else    check("blocked_idle", o_blocked, 0);
        end
        pb = o_busy;
      end else pb = 1'b0;
    end
  end

  // Wall ROM responder with configurable ack latency.
  initial begin
    int idx, last;
    idx = 0; last = -1;
    forever begin
      @(negedge clk);
      if (resp_en && o_wall_req) begin
        if (mv_id != last) begin last = mv_id; idx = 0; end
        repeat (ack_delay) @(negedge clk);
        if (o_wall_req) begin
          check("req_in_range", (idx < exp_n) ? 1 : 0, 1);
          if (idx < exp_n) begin
            check("req_row", o_wall_row, exp_r[idx]);
            check("req_col", o_wall_col, exp_c[idx]);
          end
          if (idx < 2) begin seen_r[idx] = o_wall_row; seen_c[idx] = o_wall_col; end
          idx++;
          resp_data = (o_wall_row < 12 && o_wall_col < 16) ? walls[o_wall_row][o_wall_col] : 4'h0;
          resp_ack = 1'b1;
          @(negedge clk);
          resp_ack = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (o_busy && n < 60);
    check("move_done", o_busy, 0);
  endtask

  task automatic do_restart();
    @(negedge clk); i_restart = 1'b1;
    @(posedge clk); #1 i_restart = 1'b0;
    mx = 394; my = 41; exp_blocked = 1'b0;
  endtask

  task automatic do_move(input logic [3:0] btn, input bit extra);
    int col, row, xin, yin, ar, ac;
    logic [3:0] cw, aw;
    logic blk;
    bit oh;
    oh = (btn == 4'd1 || btn == 4'd2 || btn == 4'd4 || btn == 4'd8);
    col = mx / 40; xin = mx % 40; row = my / 40; yin = my % 40; ar = row; ac = col;
    case (btn)
      4'd1: if (row > 0)  ar = row - 1;
      4'd2: if (col > 0)  ac = col - 1;
      4'd4: if (col < 15) ac = col + 1;
      4'd8: if (row < 11) ar = row + 1;
      default: ;
    endcase
    cw = walls[row][col];
    aw = (ar == row && ac == col) ? 4'h0 : walls[ar][ac];
    case (btn)
      4'd1: blk = ((cw[3] | aw[2]) && yin <= 2) || (my - 2 < 0);
      4'd8: blk = ((cw[2] | aw[3]) && yin + 10 >= 38) || (my + 12 > 480);
      4'd2: blk = ((cw[1] | aw[0]) && xin <= 2) || (mx - 2 < 0);
      4'd4: blk = ((cw[0] | aw[1]) && xin + 10 >= 38) || (mx + 12 > 640);
      default: blk = 1'b0;
    endcase
    exp_r[0] = row; exp_c[0] = col; exp_r[1] = ar; exp_c[1] = ac;
    exp_n = (ar == row && ac == col) ? 1 : 2;
    mv_id++;
    @(negedge clk); i_tick = 1'b1; i_btn_dir = btn;
    @(posedge clk); #1 i_tick = 1'b0; i_btn_dir = 4'b0000;
    if (oh) begin
      exp_blocked = blk;
      if (!blk) begin
        case (btn)
          4'd1: my -= 2;
          4'd2: mx -= 2;
          4'd4: mx += 2;
          default: my += 2;
        endcase
      end
      if (extra) begin
        // A tick while busy must be dropped.
        @(negedge clk); i_tick = 1'b1; i_btn_dir = 4'b0010;
        @(posedge clk); #1 i_tick = 1'b0; i_btn_dir = 4'b0000;
      end
      wait_idle();
    end else begin
      @(negedge clk);
      check("ignored_tick_busy", o_busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] btns [10];
    btns = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd5};
    for (int r = 0; r < 12; r++) for (int c = 0; c < 16; c++) walls[r][c] = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_pos_x", o_pos_x, 394);
    check("rst_pos_y", o_pos_y, 141);
    check("rst_col", o_tile_col, 9);
    check("rst_row", o_tile_row, 1);
    check("rst_busy", o_busy, 0);
    check("rst_req", o_wall_req, 0);
    chk_en = 1'b1;

    ack_delay = 2;
    do_move(4'b0100, 1'b0);
    check("right_pos_x", o_pos_x, 396);
    check("right_col", o_tile_col, 9);
    check("right_blocked", o_blocked, 0);
    check("right_req0_row", seen_r[0], 1);
    check("right_req0_col", seen_c[0], 9);
    check("right_req1_row", seen_r[1], 1);
    check("right_req1_col", seen_c[1], 10);

    do_restart();
    ack_delay = 0;
    do_move(4'b0001, 1'b0);
    check("up_pos_y", o_pos_y, 139);
    check("up_row", o_tile_row, 0);

    do_restart();
    walls[1][9] = 4'b1000;
    do_move(4'b0001, 1'b0);
    check("wall_blocked", o_blocked, 1);
    check("wall_pos_y", o_pos_y, 141);
    @(negedge clk);
    check("wall_blocked_done", o_blocked, 0);
    walls[1][9] = 4'h0;

    do_restart();
    repeat (20) do_move(4'b0001, 1'b0);
    check("top_pos_y", o_pos_y, 101);
    do_move(4'b0001, 1'b0);
    check("edge_blocked", o_blocked, 1);
    check("edge_pos_y", o_pos_y, 101);
    do_move(4'b0101, 1'b0);
    do_move(4'b0000, 1'b0);
    ack_delay = 3;
    do_move(4'b1000, 1'b1);
    check("busy_drop_pos_x", o_pos_x, 394);

    do_restart();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 16; c++) walls[r][c] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    for (int i = 0; i < 60; i++) begin
      ack_delay = $urandom_range(0, 3);
      do_move(btns[$urandom_range(0, 9)], (i % 7) == 0);
    end

    for (int r = 0; r < 12; r++) for (int c = 0; c < 16; c++) walls[r][c] = 4'h0;
    do_restart();
    ack_delay = 0;
    do_move(4'b0010, 1'b0);
    resp_en = 1'b0;
    exp_blocked = 1'b0;
    @(negedge clk); i_tick = 1'b1; i_btn_dir = 4'b0100;
    @(posedge clk); #1 i_tick = 1'b0; i_btn_dir = 4'b0000;
    @(negedge clk); man_ack = 1'b1; man_data = 4'h0;
    @(posedge clk); #1 man_ack = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_wall_req && n < 10);
    check("adj_req_seen", o_wall_req, 1);
    check("adj_req_col", o_wall_col, 10);
    i_level_change = 1'b1;
    @(posedge clk); #1 i_level_change = 1'b0;
    mx = 394; my = 41;
    @(negedge clk);
    check("abort_req", o_wall_req, 0);
    check("abort_pos_x", o_pos_x, 394);
    check("abort_pos_y", o_pos_y, 141);
    man_ack = 1'b1; man_data = 4'hF;
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_busy", o_busy, 0);
    check("stray_ack_pos_x", o_pos_x, 394);
    resp_en = 1'b1;
    do_move(4'b1000, 1'b0);
    check("after_abort_pos_y", o_pos_y, 143);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
